// File: rtl/out_fifo_pkg.sv
// Shared width helpers and parameter legality checks for the multi-channel output FIFO.
package out_fifo_pkg;

    localparam int MAX_RATIO = 4;
    localparam int MIN_DEPTH = 4;
    localparam int MAX_DEPTH = 64;

    function automatic int sw_f(input int din_w, input int ratio);
        return din_w / ratio;
    endfunction

    function automatic int ptr_w_f(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int lvl_w_f(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // A single-slice configuration still needs a 1-bit counter to keep widths legal.
    function automatic int slc_w_f(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic bit cfg_ok_f(input int din_w, input int ratio, input int depth,
                                    input int ae_value, input int af_value);
        bit ok;
        ok = (ratio == 1 || ratio == 2 || ratio == MAX_RATIO);
        ok = ok && (din_w % ratio == 0);
        ok = ok && (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) && ((depth & (depth - 1)) == 0);
        ok = ok && (ae_value >= 1) && (ae_value <= depth * ratio - 1);
        ok = ok && (af_value >= 1) && (af_value <= depth - 1);
        return ok;
    endfunction

endpackage

// File: rtl/out_fifo_ctrl.sv
// Shared pointer, slice counter, LEVEL and flag control for all FIFO channels.
// Optional OUT_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module out_fifo_ctrl
    import out_fifo_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int RATIO    = 2,
    parameter int AE_VALUE = 1,
    parameter int AF_VALUE = 1,
    localparam int PW = ptr_w_f(DEPTH),
    localparam int LW = lvl_w_f(DEPTH),
    localparam int CW = slc_w_f(RATIO)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wren,
    input  logic          rden,
    output logic          we,
    output logic          re,
    output logic [PW-1:0] waddr,
    output logic [PW-1:0] raddr,
    output logic [CW-1:0] slc,
    output logic          empty,
    output logic          full,
    output logic          almostempty,
    output logic          almostfull,
    output logic [LW-1:0] level
`ifdef OUT_FIFO_ERR_FLAGS_EN
    ,
    output logic          overflow,
    output logic          underflow
`endif
);

    // Slices remaining can reach DEPTH*RATIO, up to two bits wider than LEVEL.
    localparam int RW = LW + 2;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] slc_r, slc_nxt;
    logic [LW-1:0] level_r, level_nxt, room_nxt;
    logic [RW-1:0] rem_nxt;
    logic          wr_acc, rd_acc, last_slc, free_ent;

    always_comb begin
        wr_acc    = wren & ~full;
        rd_acc    = rden & ~empty;
        last_slc  = (slc_r == CW'(RATIO - 1));
        free_ent  = rd_acc & last_slc;
        level_nxt = level_r + LW'(wr_acc) - LW'(free_ent);
        slc_nxt   = slc_r;
        if (rd_acc) begin
            slc_nxt = last_slc ? '0 : slc_r + CW'(1);
        end
        rem_nxt   = RW'(level_nxt) * RW'(RATIO) - RW'(slc_nxt);
        room_nxt  = LW'(DEPTH) - level_nxt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            slc_r       <= '0;
            level_r     <= '0;
            empty       <= 1'b1;
            almostempty <= 1'b1;
            full        <= 1'b0;
            almostfull  <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (free_ent) rd_ptr <= rd_ptr + PW'(1);
            slc_r       <= slc_nxt;
            level_r     <= level_nxt;
            empty       <= (rem_nxt == '0);
            full        <= (level_nxt == LW'(DEPTH));
            almostempty <= (rem_nxt <= RW'(AE_VALUE));
            almostfull  <= (room_nxt <= LW'(AF_VALUE));
        end
    end

`ifdef OUT_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wren & full) overflow <= 1'b1;
            if (rden & empty) underflow <= 1'b1;
        end
    end
`endif

    assign we    = wr_acc;
    assign re    = rd_acc;
    assign waddr = wr_ptr;
    assign raddr = rd_ptr;
    assign slc   = slc_r;
    assign level = level_r;

endmodule

// File: rtl/out_fifo_array.sv
// Parametrised multi-channel output FIFO: wide writes, LSB-first narrow slice reads.
// Optional OUT_FIFO_ERR_FLAGS_EN adds OVERFLOW/UNDERFLOW sticky outputs.
module out_fifo_array
    import out_fifo_pkg::*;
#(
    parameter int NUM_CH   = 10,
    parameter int DIN_W    = 8,
    parameter int RATIO    = 2,
    parameter int DEPTH    = 8,
    parameter int AE_VALUE = 1,
    parameter int AF_VALUE = 1,
    localparam int SW = sw_f(DIN_W, RATIO),
    localparam int LW = lvl_w_f(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 WREN,
    input  logic [NUM_CH*DIN_W-1:0] D,
    input  logic                 RDEN,
    output logic [NUM_CH*SW-1:0] Q,
    output logic                 EMPTY,
    output logic                 FULL,
    output logic                 ALMOSTEMPTY,
    output logic                 ALMOSTFULL,
    output logic [LW-1:0]        LEVEL
`ifdef OUT_FIFO_ERR_FLAGS_EN
    ,
    output logic                 OVERFLOW,
    output logic                 UNDERFLOW
`endif
);

    localparam int PW = ptr_w_f(DEPTH);
    localparam int CW = slc_w_f(RATIO);

    if (!cfg_ok_f(DIN_W, RATIO, DEPTH, AE_VALUE, AF_VALUE)) begin : g_cfg_err
        $error("out_fifo_array: illegal DIN_W/RATIO/DEPTH/AE_VALUE/AF_VALUE combination");
    end

    logic          we, re;
    logic [PW-1:0] waddr, raddr;
    logic [CW-1:0] slc;

    out_fifo_ctrl #(
        .DEPTH    (DEPTH),
        .RATIO    (RATIO),
        .AE_VALUE (AE_VALUE),
        .AF_VALUE (AF_VALUE)
    ) u_ctrl (
        .clk         (CLK),
        .resetn      (RESETN),
        .wren        (WREN),
        .rden        (RDEN),
        .we          (we),
        .re          (re),
        .waddr       (waddr),
        .raddr       (raddr),
        .slc         (slc),
        .empty       (EMPTY),
        .full        (FULL),
        .almostempty (ALMOSTEMPTY),
        .almostfull  (ALMOSTFULL),
        .level       (LEVEL)
`ifdef OUT_FIFO_ERR_FLAGS_EN
        ,
        .overflow    (OVERFLOW),
        .underflow   (UNDERFLOW)
`endif
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DIN_W-1:0] mem [DEPTH];
        logic [DIN_W-1:0] rd_word;
        logic [SW-1:0]    q_p1;

        always_ff @(posedge CLK) begin
            if (we) mem[waddr] <= D[c*DIN_W +: DIN_W];
        end

        assign rd_word = mem[raddr];

        // Read stage: slice mux registered into the output lane.
        always_ff @(posedge CLK) begin
            if (!RESETN) begin
                q_p1 <= '0;
            end else if (re) begin
                q_p1 <= rd_word[int'(slc)*SW +: SW];
            end
        end

        assign Q[c*SW +: SW] = q_p1;
    end

endmodule

// File: tb/tb_out_fifo_array.sv
// Directed bench for out_fifo_array: hand-computed vector table plus queue-model sequences.
module tb_out_fifo_array;

    localparam int NUM_CH = 10;
    localparam int DIN_W  = 8;
    localparam int RATIO  = 2;
    localparam int DEPTH  = 8;
    localparam int SW     = DIN_W / RATIO;

    logic                    CLK;
    logic                    RESETN;
    logic                    WREN;
    logic                    RDEN;
    logic [NUM_CH*DIN_W-1:0] D;
    logic [NUM_CH*SW-1:0]    Q;
    logic                    EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL;
    logic [3:0]              LEVEL;
`ifdef OUT_FIFO_ERR_FLAGS_EN
    logic                    OVERFLOW, UNDERFLOW;
`endif

    out_fifo_array #(
        .NUM_CH(NUM_CH), .DIN_W(DIN_W), .RATIO(RATIO), .DEPTH(DEPTH),
        .AE_VALUE(1), .AF_VALUE(1)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .WREN(WREN), .D(D), .RDEN(RDEN), .Q(Q),
        .EMPTY(EMPTY), .FULL(FULL), .ALMOSTEMPTY(ALMOSTEMPTY), .ALMOSTFULL(ALMOSTFULL),
        .LEVEL(LEVEL)
`ifdef OUT_FIFO_ERR_FLAGS_EN
        , .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       rstn, wr, rd;
        logic [7:0] din;
        logic       qz;
        logic [3:0] q0;
        logic       e, f, ae, af;
        logic [3:0] lvl;
    } vec_t;

    function automatic vec_t mk(input logic rstn, input logic wr, input logic rd, input logic [7:0] din,
                                input logic qz, input logic [3:0] q0, input logic e, input logic f,
                                input logic ae, input logic af, input logic [3:0] lvl);
        vec_t v;
        v.rstn = rstn; v.wr = wr; v.rd = rd; v.din = din; v.qz = qz; v.q0 = q0;
        v.e = e; v.f = f; v.ae = ae; v.af = af; v.lvl = lvl;
        return v;
    endfunction

    // Entry data for the model-driven sequences: distinct per entry id and channel.
    function automatic logic [NUM_CH*DIN_W-1:0] ent(input int k);
        logic [NUM_CH*DIN_W-1:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c*DIN_W +: DIN_W] = 8'((k * 37 + c * 11 + 5) & 255);
        return r;
    endfunction

    int                   mq[$];
    int                   mslc;
    int                   next_id;
    logic [NUM_CH*SW-1:0] mqv;
    logic                 movf, mudf;

    task automatic cyc(input logic rstn, input logic wr, input logic rd, input string tag);
        int  lvl, rem;
        bit  wr_ok, rd_ok;
        logic [NUM_CH*DIN_W-1:0] e;
        RESETN = rstn; WREN = wr; RDEN = rd; D = ent(next_id);
        @(posedge CLK); #1;
        if (!rstn) begin
            mq.delete(); mslc = 0; mqv = '0; movf = 0; mudf = 0;
        end else begin
            lvl   = mq.size();
            rem   = lvl * RATIO - mslc;
            wr_ok = wr && (lvl < DEPTH);
            rd_ok = rd && (rem > 0);
            if (wr && !wr_ok) movf = 1;
            if (rd && !rd_ok) mudf = 1;
            if (rd_ok) begin
                e = ent(mq[0]);
                for (int c = 0; c < NUM_CH; c++) mqv[c*SW +: SW] = e[c*DIN_W + mslc*SW +: SW];
                mslc++;
                if (mslc == RATIO) begin
                    mslc = 0;
                    void'(mq.pop_front());
                end
            end
            if (wr_ok) begin
                mq.push_back(next_id);
                next_id++;
            end
        end
        lvl = mq.size();
        rem = lvl * RATIO - mslc;
        chk({tag, "_q"}, 80'(Q), 80'(mqv));
        chk({tag, "_level"}, 80'(LEVEL), 80'(lvl));
        chk({tag, "_empty"}, 80'(EMPTY), 80'(rem == 0));
        chk({tag, "_full"}, 80'(FULL), 80'(lvl == DEPTH));
        chk({tag, "_ae"}, 80'(ALMOSTEMPTY), 80'(rem <= 1));
        chk({tag, "_af"}, 80'(ALMOSTFULL), 80'((DEPTH - lvl) <= 1));
`ifdef OUT_FIFO_ERR_FLAGS_EN
        chk({tag, "_ovf"}, 80'(OVERFLOW), 80'(movf));
        chk({tag, "_udf"}, 80'(UNDERFLOW), 80'(mudf));
`endif
    endtask

    vec_t tbl[11];

    initial begin
        logic [NUM_CH*SW-1:0] qexp;
        int dmax;
        RESETN = 1'b0; WREN = 1'b0; RDEN = 1'b0; D = '0;
        mq.delete(); mslc = 0; next_id = 0; mqv = '0; movf = 0; mudf = 0;

        //          rstn wr rd din    qz q0    e  f  ae af lvl
        tbl[0]  = mk(0,  0, 0, 8'h00, 1, 4'h0, 1, 0, 1, 0, 4'd0);
        tbl[1]  = mk(1,  0, 0, 8'h00, 1, 4'h0, 1, 0, 1, 0, 4'd0);
        tbl[2]  = mk(1,  1, 0, 8'hA5, 1, 4'h0, 0, 0, 0, 0, 4'd1);
        tbl[3]  = mk(1,  0, 1, 8'h00, 0, 4'h5, 0, 0, 1, 0, 4'd1);
        tbl[4]  = mk(1,  0, 1, 8'h00, 0, 4'hA, 1, 0, 1, 0, 4'd0);
        tbl[5]  = mk(1,  0, 1, 8'h00, 0, 4'hA, 1, 0, 1, 0, 4'd0);
        tbl[6]  = mk(1,  1, 1, 8'h3C, 0, 4'hA, 0, 0, 0, 0, 4'd1);
        tbl[7]  = mk(1,  1, 1, 8'h7E, 0, 4'hC, 0, 0, 0, 0, 4'd2);
        tbl[8]  = mk(1,  0, 1, 8'h00, 0, 4'h3, 0, 0, 0, 0, 4'd1);
        tbl[9]  = mk(1,  0, 1, 8'h00, 0, 4'hE, 0, 0, 1, 0, 4'd1);
        tbl[10] = mk(1,  0, 1, 8'h00, 0, 4'h7, 1, 0, 1, 0, 4'd0);

        // Channel c carries din ^ {c,c}, so its expected slice is q0 ^ c.
        for (int i = 0; i < 11; i++) begin
            RESETN = tbl[i].rstn; WREN = tbl[i].wr; RDEN = tbl[i].rd;
            for (int c = 0; c < NUM_CH; c++) D[c*DIN_W +: DIN_W] = tbl[i].din ^ {4'(c), 4'(c)};
            @(posedge CLK); #1;
            for (int c = 0; c < NUM_CH; c++) qexp[c*SW +: SW] = tbl[i].qz ? 4'h0 : (tbl[i].q0 ^ 4'(c));
            chk($sformatf("t%0d_q", i), 80'(Q), 80'(qexp));
            chk($sformatf("t%0d_empty", i), 80'(EMPTY), 80'(tbl[i].e));
            chk($sformatf("t%0d_full", i), 80'(FULL), 80'(tbl[i].f));
            chk($sformatf("t%0d_ae", i), 80'(ALMOSTEMPTY), 80'(tbl[i].ae));
            chk($sformatf("t%0d_af", i), 80'(ALMOSTFULL), 80'(tbl[i].af));
            chk($sformatf("t%0d_level", i), 80'(LEVEL), 80'(tbl[i].lvl));
        end

        // Fill to FULL, drop a ninth write, then drain all slices in order.
        cyc(0, 0, 0, "a_rst");
        for (int i = 0; i < 7; i++) cyc(1, 1, 0, "a_fill");
        chk("a_level7", 80'(LEVEL), 80'd7);
        chk("a_af_at7", 80'(ALMOSTFULL), 80'd1);
        chk("a_notfull7", 80'(FULL), 80'd0);
        cyc(1, 1, 0, "a_fill8");
        chk("a_full8", 80'(FULL), 80'd1);
        cyc(1, 1, 0, "a_drop");
        chk("a_drop_level", 80'(LEVEL), 80'd8);
`ifdef OUT_FIFO_ERR_FLAGS_EN
        chk("a_overflow", 80'(OVERFLOW), 80'd1);
`endif
        for (int i = 0; i < 16; i++) cyc(1, 0, 1, "a_drain");
        chk("a_empty_end", 80'(EMPTY), 80'd1);

        // At FULL, write+read for two cycles: writes rejected until FULL drops.
        cyc(0, 0, 0, "b_rst");
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, "b_fill");
        cyc(1, 1, 1, "b_wr1");
        chk("b_full_after1", 80'(FULL), 80'd1);
        cyc(1, 1, 1, "b_wr2");
        chk("b_full_after2", 80'(FULL), 80'd0);
        chk("b_level_after2", 80'(LEVEL), 80'd7);
        cyc(1, 1, 0, "b_wr3");
        chk("b_full_after3", 80'(FULL), 80'd1);
        for (int i = 0; i < 16; i++) cyc(1, 0, 1, "b_drain");

        // Stream 20 entries against continuous reads, wrapping the pointers.
        cyc(0, 0, 0, "c_rst");
        begin
            int target;
            target = next_id + 20;
            dmax = 0;
            for (int i = 0; i < 300; i++) begin
                if (next_id >= target && mq.size() == 0) break;
                cyc(1, next_id < target, 1, "c_stream");
                if (int'(LEVEL) > dmax) dmax = int'(LEVEL);
            end
        end
        chk("c_level_le_depth", 80'(dmax > DEPTH), 80'd0);
        chk("c_drained", 80'(EMPTY), 80'd1);

        // Reset with LEVEL=5, slc=1 discards everything, including the request in the reset cycle.
        cyc(0, 0, 0, "d_rst0");
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, "d_fill");
        cyc(1, 0, 1, "d_half");
        chk("d_level5", 80'(LEVEL), 80'd5);
        cyc(0, 1, 1, "d_rst");
        chk("d_rst_level", 80'(LEVEL), 80'd0);
        chk("d_rst_empty", 80'(EMPTY), 80'd1);
        chk("d_rst_q", 80'(Q), 80'd0);
        cyc(1, 1, 0, "d_new_wr");
        cyc(1, 0, 1, "d_new_rd0");
        cyc(1, 0, 1, "d_new_rd1");
        chk("d_new_empty", 80'(EMPTY), 80'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
